lfsr_rng_gen: RTL and testbench

//  Parametrised Fibonacci LFSR pseudo-random source: configurable width/taps/seed,

---
 rtl/lfsr_rng_gen.sv | 139 +++++++++++++
 tb/tb_lfsr_rng_gen.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_rng_gen.sv
// ----------------------------------------------------------------------------
// lfsr_rng_gen
// Parametrised Fibonacci LFSR pseudo-random source with runtime reseed and
// zero-state lockup protection. Two modes: free-running (a new value every
// clock) and on-demand draws (req -> STEPS shifts -> one-cycle valid pulse).
//
// Ports
//   clk         in   1      system clock, all state on posedge
//   reset       in   1      asynchronous active-high reset
//   seed_load   in   1      load seed_in into the LFSR (highest priority)
//   seed_in     in   WIDTH  seed value; all-zero is replaced by DEFAULT_SEED
//   free_run    in   1      1 = shift every cycle, 0 = on-demand draws
//   req         in   1      draw request, honoured only in IDLE with free_run=0
//   busy        out  1      draw in progress
//   valid       out  1      rand_out holds a fresh value (pulse, or held in free_run)
//   rand_out    out  WIDTH  registered random value
//   lockup_fix  out  1      pulse: an all-zero seed was replaced by DEFAULT_SEED
// ----------------------------------------------------------------------------
module lfsr_rng_gen #(
    parameter int unsigned      WIDTH        = 13,
    parameter logic [WIDTH-1:0] TAPS         = 13'h100D,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = 13'h000F,
    parameter int unsigned      STEPS        = 13
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             free_run,
    input  logic             req,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] rand_out,
    output logic             lockup_fix
);

    localparam int unsigned      CNT_W    = $clog2(STEPS + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(STEPS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } fsm_t;

    fsm_t             fsm_q, fsm_d;
    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] rand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_d, busy_d, lockup_d;

    // One Fibonacci step of the current state
    logic             fb_c;
    logic [WIDTH-1:0] shifted_c;

    assign fb_c      = ^(state_q & TAPS);
    assign shifted_c = {state_q[WIDTH-2:0], fb_c};

    // State register and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q      <= IDLE;
            state_q    <= DEFAULT_SEED;
            cnt_q      <= '0;
            rand_out   <= DEFAULT_SEED;
            valid      <= 1'b0;
            busy       <= 1'b0;
            lockup_fix <= 1'b0;
        end else begin
            fsm_q      <= fsm_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rand_out   <= rand_d;
            valid      <= valid_d;
            busy       <= busy_d;
            lockup_fix <= lockup_d;
        end
    end

    // Next-state: seed_load beats free_run, which beats the draw FSM
    always_comb begin
        fsm_d    = fsm_q;
        state_d  = state_q;
        cnt_d    = cnt_q;
        rand_d   = rand_out;
        valid_d  = 1'b0;
        lockup_d = 1'b0;

        if (seed_load) begin
            // Reseed aborts any draw; the last delivered value stays visible
            fsm_d = IDLE;
            cnt_d = '0;
            if (seed_in == '0) begin
                state_d  = DEFAULT_SEED;
                lockup_d = 1'b1;
            end else begin
                state_d = seed_in;
            end
        end else if (free_run) begin
            fsm_d   = IDLE;
            cnt_d   = '0;
            state_d = shifted_c;
            rand_d  = shifted_c;
            valid_d = 1'b1;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (req) begin
                        state_d = shifted_c;
                        if (STEPS == 1) begin
                            rand_d  = shifted_c;
                            valid_d = 1'b1;
                        end else begin
                            cnt_d = CNT_INIT;
                            fsm_d = SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    // cnt counts shifts still owed; the last one delivers
                    state_d = shifted_c;
                    cnt_d   = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        rand_d  = shifted_c;
                        valid_d = 1'b1;
                        fsm_d   = IDLE;
                    end
                end
                default: begin
                    fsm_d = IDLE;
                    cnt_d = '0;
                end
            endcase
        end

        busy_d = (fsm_d == SHIFT);
    end

endmodule

// File: tb/tb_lfsr_rng_gen.sv
// ----------------------------------------------------------------------------
// tb_lfsr_rng_gen
// Self-checking bench for lfsr_rng_gen. Three instances: default parameters,
// STEPS=1, and a 4-bit maximal-length variant. Expected values come from a
// software LFSR model (popcount parity of state&taps, then shift-in).
// ----------------------------------------------------------------------------
module tb_lfsr_rng_gen;

    localparam int unsigned W_M     = 13;
    localparam int unsigned TAPS_M  = 32'h100D;
    localparam int unsigned SEED_M  = 32'h000F;
    localparam int unsigned STEPS_M = 13;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Default-parameter instance
    logic              reset, seed_load, free_run, req;
    logic [W_M-1:0]    seed_in;
    logic              busy, valid, lockup_fix;
    logic [W_M-1:0]    rand_out;

    // STEPS=1 instance
    logic              s1_reset, s1_free_run, s1_req;
    logic              s1_busy, s1_valid, s1_lockup_fix;
    logic [W_M-1:0]    s1_rand_out;

    // 4-bit instance
    logic              w4_reset, w4_free_run;
    logic              w4_busy, w4_valid, w4_lockup_fix;
    logic [3:0]        w4_rand_out;

    int unsigned       m_state;

    lfsr_rng_gen u_dut (
        .clk        (clk),
        .reset      (reset),
        .seed_load  (seed_load),
        .seed_in    (seed_in),
        .free_run   (free_run),
        .req        (req),
        .busy       (busy),
        .valid      (valid),
        .rand_out   (rand_out),
        .lockup_fix (lockup_fix)
    );

    lfsr_rng_gen #(.STEPS(1)) u_s1 (
        .clk        (clk),
        .reset      (s1_reset),
        .seed_load  (1'b0),
        .seed_in    (13'h0000),
        .free_run   (s1_free_run),
        .req        (s1_req),
        .busy       (s1_busy),
        .valid      (s1_valid),
        .rand_out   (s1_rand_out),
        .lockup_fix (s1_lockup_fix)
    );

    lfsr_rng_gen #(
        .WIDTH        (4),
        .TAPS         (4'b1001),
        .DEFAULT_SEED (4'h1),
        .STEPS        (3)
    ) u_w4 (
        .clk        (clk),
        .reset      (w4_reset),
        .seed_load  (1'b0),
        .seed_in    (4'h0),
        .free_run   (w4_free_run),
        .req        (1'b0),
        .busy       (w4_busy),
        .valid      (w4_valid),
        .rand_out   (w4_rand_out),
        .lockup_fix (w4_lockup_fix)
    );

    // Software LFSR: advance s by n shifts of a w-bit register
    function automatic int unsigned lfsr_adv(input int unsigned s, input int unsigned taps,
                                             input int unsigned w, input int unsigned n);
        int unsigned x;
        int unsigned modulus;
        x       = s;
        modulus = 32'd1 << w;
        for (int unsigned i = 0; i < n; i++) begin
            x = ((x * 2) % modulus) + ($countones(x & taps) % 2);
        end
        return x;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reseed while idle and check the lockup pulse and held output
    task automatic do_seed(input logic [W_M-1:0] s);
        logic [31:0] held;
        held      = 32'(rand_out);
        seed_in   = s;
        seed_load = 1'b1;
        step();
        seed_load = 1'b0;
        m_state   = (s == '0) ? SEED_M : 32'(s);
        check_eq("seed_lockup", 32'(lockup_fix), (s == '0) ? 32'd1 : 32'd0);
        check_eq("seed_busy", 32'(busy), 32'd0);
        check_eq("seed_valid", 32'(valid), 32'd0);
        check_eq("seed_hold", 32'(rand_out), held);
        step();
        check_eq("seed_lockup_clr", 32'(lockup_fix), 32'd0);
    endtask

    // One on-demand draw with random req noise while busy
    task automatic do_draw(input bit b2b);
        int unsigned exp_v;
        logic [31:0] held;
        exp_v = lfsr_adv(m_state, TAPS_M, W_M, STEPS_M);
        held  = 32'(rand_out);
        req   = 1'b1;
        step();
        req   = 1'($urandom);
        for (int i = 0; i < int'(STEPS_M) - 1; i++) begin
            check_eq("draw_busy", 32'(busy), 32'd1);
            check_eq("draw_valid_early", 32'(valid), 32'd0);
            check_eq("draw_hold", 32'(rand_out), held);
            step();
            req = 1'($urandom);
        end
        req = 1'b0;
        check_eq("draw_valid", 32'(valid), 32'd1);
        check_eq("draw_busy_end", 32'(busy), 32'd0);
        check_eq("draw_value", 32'(rand_out), exp_v);
        m_state = exp_v;
        if (!b2b) begin
            step();
            check_eq("draw_valid_drop", 32'(valid), 32'd0);
            check_eq("draw_idle", 32'(busy), 32'd0);
            check_eq("draw_keep", 32'(rand_out), exp_v);
        end
    endtask

    initial begin
        int unsigned exp_tbl [4];
        int unsigned s;
        int unsigned vals [16];
        int          dups;

        exp_tbl = '{32'h001F, 32'h003F, 32'h007F, 32'h00FF};

        reset = 1'b1; seed_load = 1'b0; seed_in = '0; free_run = 1'b1; req = 1'b0;
        s1_reset = 1'b1; s1_free_run = 1'b0; s1_req = 1'b0;
        w4_reset = 1'b1; w4_free_run = 1'b1;

        // Reset values, asynchronously and after edges
        #3;
        check_eq("rst_rand_async", 32'(rand_out), SEED_M);
        step();
        step();
        check_eq("rst_rand", 32'(rand_out), SEED_M);
        check_eq("rst_valid", 32'(valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_lockup", 32'(lockup_fix), 32'd0);

        // Free-running from the default seed
        reset   = 1'b0;
        m_state = SEED_M;
        for (int i = 0; i < 4; i++) begin
            step();
            m_state = lfsr_adv(m_state, TAPS_M, W_M, 1);
            check_eq("fr_table", 32'(rand_out), exp_tbl[i]);
            check_eq("fr_model", 32'(rand_out), m_state);
            check_eq("fr_valid", 32'(valid), 32'd1);
        end
        for (int i = 0; i < 30; i++) begin
            req = 1'($urandom);
            step();
            m_state = lfsr_adv(m_state, TAPS_M, W_M, 1);
            check_eq("fr_rand", 32'(rand_out), m_state);
            check_eq("fr_busy", 32'(busy), 32'd0);
        end
        req = 1'b0;

        // free_run 1->0: valid drops, value kept
        free_run = 1'b0;
        step();
        check_eq("fr_off_valid", 32'(valid), 32'd0);
        check_eq("fr_off_keep", 32'(rand_out), m_state);

        // Seed handling
        do_seed(13'h0000);
        check_eq("seed_zero_state", m_state, SEED_M);
        do_seed(13'h1234);
        free_run = 1'b1;
        step();
        check_eq("seed_1234_next", 32'(rand_out), 32'h0468);
        m_state = lfsr_adv(m_state, TAPS_M, W_M, 1);
        check_eq("seed_1234_model", 32'(rand_out), m_state);
        free_run = 1'b0;
        step();

        // Randomised draws with occasional reseeds and back-to-back requests
        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                do_seed(($urandom_range(0, 2) == 0) ? 13'h0000 : 13'($urandom));
            end
            do_draw((i != 11) && ($urandom_range(0, 1) == 1));
        end

        // seed_load on the 5th shift abandons the draw
        s   = m_state;
        req = 1'b1;
        step();
        req = 1'b0;
        for (int i = 0; i < 3; i++) step();
        seed_in   = 13'h0ABC;
        seed_load = 1'b1;
        step();
        seed_load = 1'b0;
        check_eq("abort_seed_busy", 32'(busy), 32'd0);
        check_eq("abort_seed_valid", 32'(valid), 32'd0);
        check_eq("abort_seed_hold", 32'(rand_out), m_state);
        for (int i = 0; i < int'(STEPS_M) + 2; i++) begin
            step();
            check_eq("abort_seed_novalid", 32'(valid), 32'd0);
        end
        m_state = 32'h0ABC;
        do_draw(1'b0);

        // free_run asserted mid-draw abandons it and free-runs from there
        s   = m_state;
        req = 1'b1;
        step();
        req = 1'b0;
        for (int i = 0; i < 3; i++) step();
        free_run = 1'b1;
        step();
        m_state = lfsr_adv(s, TAPS_M, W_M, 5);
        check_eq("abort_fr_valid", 32'(valid), 32'd1);
        check_eq("abort_fr_busy", 32'(busy), 32'd0);
        check_eq("abort_fr_rand", 32'(rand_out), m_state);
        free_run = 1'b0;
        step();
        check_eq("abort_fr_drop", 32'(valid), 32'd0);
        step();
        check_eq("abort_fr_idle", 32'(busy), 32'd0);
        do_draw(1'b0);

        // Async reset mid-draw, observed before the next edge
        req = 1'b1;
        step();
        req = 1'b0;
        step();
        step();
        #2;
        reset = 1'b1;
        #1;
        check_eq("areset_rand", 32'(rand_out), SEED_M);
        check_eq("areset_busy", 32'(busy), 32'd0);
        check_eq("areset_valid", 32'(valid), 32'd0);
        check_eq("areset_lockup", 32'(lockup_fix), 32'd0);
        step();
        reset   = 1'b0;
        m_state = SEED_M;
        do_draw(1'b0);

        // STEPS=1 draws
        s1_reset = 1'b0;
        step();
        s1_req = 1'b1;
        step();
        s1_req = 1'b0;
        check_eq("s1_valid_1", 32'(s1_valid), 32'd1);
        check_eq("s1_rand_1", 32'(s1_rand_out), 32'h001F);
        step();
        check_eq("s1_valid_drop", 32'(s1_valid), 32'd0);
        s1_req = 1'b1;
        step();
        s1_req = 1'b0;
        check_eq("s1_rand_2", 32'(s1_rand_out), 32'h003F);
        s = 32'h003F;
        s1_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            s = lfsr_adv(s, TAPS_M, W_M, 1);
            check_eq("s1_b2b_valid", 32'(s1_valid), 32'd1);
            check_eq("s1_b2b_rand", 32'(s1_rand_out), s);
            check_eq("s1_busy", 32'(s1_busy), 32'd0);
        end
        s1_req = 1'b0;
        check_eq("s1_lockup", 32'(s1_lockup_fix), 32'd0);

        // 4-bit maximal-length period
        w4_reset = 1'b0;
        vals[0]  = 32'(w4_rand_out);
        check_eq("w4_start", vals[0], 32'd1);
        for (int i = 1; i < 16; i++) begin
            step();
            vals[i] = 32'(w4_rand_out);
            check_eq("w4_model", vals[i], lfsr_adv(1, 32'h9, 4, i));
            check_eq("w4_nonzero", 32'(vals[i] != 0), 32'd1);
        end
        dups = 0;
        for (int i = 0; i < 15; i++) begin
            for (int j = i + 1; j < 15; j++) begin
                if (vals[i] == vals[j]) dups++;
            end
        end
        check_eq("w4_distinct", 32'(dups), 32'd0);
        check_eq("w4_period", vals[15], vals[0]);
        check_eq("w4_valid", 32'(w4_valid), 32'd1);
        check_eq("w4_busy", 32'(w4_busy), 32'd0);
        check_eq("w4_lockup", 32'(w4_lockup_fix), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
